srl_fifo_ctrl: RTL and testbench
================================

Name: srl_fifo_ctrl

Overview:
- Synchronous first-word-fall-through FIFO built on an addressable shift register, the structure Xilinx maps to SRL16E/SRLC32E.
- Controller owns the occupancy counter, the shift-enable and the dynamic read address, and wraps the storage with valid/ready handshakes.
- Sits between a producer and a consumer in the same clock domain.
- Used as the controlled-datapath test case for SRL inference in synth_xilinx flows.

Parameters:
- WIDTH, 8, data bits per entry (>=1).
- DEPTH, 16, number of entries (2..32, so the storage maps to one SRL per bit).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous empty request.
- in_data  input  WIDTH  write data.
- in_valid  input  1  producer has data.
- in_ready  output  1  FIFO accepts data.
- out_data  output  WIDTH  oldest entry (FWFT).
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer takes the entry.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset clears only count, to 0.
- Outputs after reset: empty=1, full=0, almost_full=0, in_ready=1, out_valid=0.
- Storage is never reset, because SRL primitives have no reset. out_data is don't-care while out_valid=0.
- Storage: stage[0..DEPTH-1]. On a push, stage[0]<=in_data and stage[k]<=stage[k-1]. No other write path exists; shift enable = push.
- Read path: out_data = stage[count-1], combinational from the count register. When count=0 the address is 0.
- Handshake signals:
  - in_ready = !full, driven from the registered count only, with no combinational path from out_ready.
  - out_valid = !empty.
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. The shift moves the next-oldest entry to address count-1.
  - neither: unchanged.
- Full: no push is possible, so a pop on a full FIFO only decrements. Count never exceeds DEPTH.
- Empty: no pop is possible. Count never underflows.
- Flush: count<=0 next cycle. It overrides push and pop in the same cycle; that cycle's data is dropped and no shift occurs.
- Reset priority: rst overrides flush, push and pop. Reset mid-stream drops all entries.
- Latency: data pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1 if the FIFO was empty.
- Status flags: full, empty and almost_full are pure decodes of the registered count, with no extra latency.
- Ordering: strict FIFO order is preserved under any mix of push, pop and stall.
- Synthesis result (synth_xilinx): count, control and flags use LUT/FF only. Storage maps to WIDTH SRL cells with dynamic address. No block RAM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> count=0, empty=1, in_ready=1, out_valid=0, almost_full=0.
- Fill: push 0x01..0x10 back-to-back with out_ready=0 (DEPTH=16).
  - almost_full rises in the cycle after the 12th push; full=1 and in_ready=0 after the 16th.
  - A 17th in_valid=1 is not accepted: count stays 16.
- Drain in order: from full, out_ready=1 with in_valid=0 for 16 cycles -> out_data sequence 0x01..0x10, then empty=1 and count=0.
- Simultaneous push/pop: with count=3 holding A,B,C, push D while popping -> out_data A then B, count stays 3. Subsequent pops give C, D.
- Flush and reset priority:
  - count=5; flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0 and the pushed word is absent.
  - Separately, rst=1 with flush=0 and a push pending -> count=0.
- Random stress against a reference queue model: 2000 cycles of random in_valid, out_ready, and flush at 2% -> out_data matches the model on every pop, count matches the model every cycle, and no push occurs while full=1.

Source files
------------

// File: rtl/srl_fifo_if.sv
// Valid/ready handshake bundle between a producer, the SRL FIFO and a consumer.
// The FIFO takes the slave view; the surrounding environment drives the master view.
interface srl_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// First-word-fall-through FIFO on an addressable shift register (SRL16E/SRLC32E style).
// Only the occupancy counter is reset; the shift storage is read at address count-1.
module srl_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  srl_fifo_if.slave     fifo,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    rd_addr;
  logic             push;
  logic             pop;

  // Flags decode the registered count only, so in_ready never depends on out_ready.
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;

  assign fifo.in_ready  = ~full;
  assign fifo.out_valid = ~empty;

  assign push = fifo.in_valid & ~full & ~flush & ~rst;
  assign pop  = fifo.out_valid & fifo.out_ready & ~flush;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; SRL primitives cannot be reset and validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      stage_q[0] <= fifo.in_data;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  // The oldest entry sits at count-1; a simultaneous push shifts the next-oldest into that slot.
  assign rd_addr       = empty ? '0 : AW'(count_q - CW'(1));
  assign fifo.out_data = stage_q[rd_addr];

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed and model-based checks for srl_fifo_ctrl (WIDTH=8, DEPTH=16, AF_LEVEL=12).
module tb_srl_fifo_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;

  int checks = 0;
  int errors = 0;

  srl_fifo_if #(.WIDTH(WIDTH)) bus ();

  srl_fifo_ctrl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fifo        (bus.slave),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      step();
      checks++;
      if (count !== CW'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
      checks++;
      if (almost_full !== (i >= AF_LEVEL)) begin
        errors++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, (i >= AF_LEVEL));
      end
      checks++;
      if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == DEPTH)); end
      checks++;
      if (bus.in_ready !== (i < DEPTH)) begin
        errors++; $display("FAIL fill_in_ready[%0d]: got %b expected %b", i, bus.in_ready, (i < DEPTH));
      end
      checks++;
      if (bus.out_data !== 8'h01 || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL fill_head[%0d]: got %0h/%b expected 01/1", i, bus.out_data, bus.out_valid);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (count !== CW'(DEPTH)) begin errors++; $display("FAIL overfill_count: got %0d expected %0d", count, DEPTH); end
  endtask

  task automatic test_drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
        errors++; $display("FAIL drain_data[%0d]: got %0h/%b expected %0h/1", i, bus.out_data, bus.out_valid, i);
      end
      step();
    end
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 0) begin errors++; $display("FAIL drain_empty: got %b/%0d expected 1/0", empty, count); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = seq[i];
      step();
    end
    bus.in_data   = seq[3];
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 8'hA1) begin errors++; $display("FAIL simul_head: got %0h expected a1", bus.out_data); end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3) begin errors++; $display("FAIL simul_count: got %0d expected 3", count); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== seq[i]) begin
        errors++; $display("FAIL simul_pop[%0d]: got %0h/%b expected %0h/1", i, bus.out_data, bus.out_valid, seq[i]);
      end
      step();
    end
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b expected 1", empty); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h30 + i);
      step();
    end
    checks++;
    if (count !== 5) begin errors++; $display("FAIL flush_precount: got %0d expected 5", count); end
    flush         = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b1;
    step();
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = 8'h66;
    #1;
    checks++;
    if (count !== 0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d/%b expected 0/1", count, empty); end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 1 || bus.out_data !== 8'h66) begin
      errors++; $display("FAIL flush_dropped: got %0d/%0h expected 1/66", count, bus.out_data);
    end
  endtask

  task automatic test_reset_priority();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    rst          = 1'b1;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_prio: got %0d/%b expected 0/0", count, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] model [$];
    bit         do_push;
    bit         do_pop;
    model.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 99) < 2);
      #1;
      checks++;
      if (count !== CW'(model.size())) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", cyc, count, model.size());
      end
      checks++;
      if (bus.in_ready !== (model.size() != DEPTH)) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", cyc, bus.in_ready, (model.size() != DEPTH));
      end
      do_pop  = (model.size() > 0) && bus.out_ready && !flush;
      do_push = bus.in_valid && (model.size() < DEPTH) && !flush;
      if (do_pop) begin
        checks++;
        if (bus.out_data !== model[0]) begin
          errors++; $display("FAIL rand_data[%0d]: got %0h expected %0h", cyc, bus.out_data, model[0]);
        end
      end
      if (flush) begin
        model.delete();
      end else begin
        if (do_pop) void'(model.pop_front());
        if (do_push) model.push_back(bus.in_data);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
